fetch_sequencer: RTL and testbench

//  Parametrised fetch/sequencing unit: next-generation PC block for the core top level.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/sat_counter.sv | 23 ++
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch/sequencing unit.
package fetch_pkg;

   // Sequencer states; encoding is exposed on the debug state output.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_INIT   = 2'd1,
      ST_RUN    = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   // Working width of the sign-extension helper; PC_W must not exceed it.
   localparam int SEXT_W = 64;

   // Sign-extend the low w bits of v to the full helper width.
   function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                              input int unsigned       w);
      logic [SEXT_W-1:0] mask;
      logic [5:0]        msb;
      mask = {SEXT_W{1'b1}} << w;
      msb  = 6'(w - 1);
      sext = v[msb] ? (v | mask) : (v & ~mask);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RST_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear wins over increment; increment stops once all bits are set.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/sequencing unit: owns the PC and instruction register, handles
// start/halt sequencing, stall hold and branch redirect, and keeps
// saturating cycle and retired-instruction counters.
// There is no valid/ready handshake here: instr_valid is a plain qualifier
// on instr_out/ir_pc, and stall is an unconditional hold request from
// downstream that freezes pc, IR and instr_valid for the cycle it is high.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 9,
   parameter int              CNT_W    = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              BR_REL   = 0
) (
   input  logic               CLK,
   input  logic               RST_n,
   input  logic               start,
   input  logic               stall,
   input  logic               branch,
   input  logic [PC_W-1:0]    branch_target,
   input  logic               halt_req,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    ir_pc,
   output logic               instr_valid,
   output logic               halted,
   output logic               pc_wrap,
   output logic [CNT_W-1:0]   cycle_ct,
   output logic [CNT_W-1:0]   instr_ct,
   output logic [1:0]         dbg_state
);

   state_e          state;
   logic [PC_W-1:0] rel_target;
   logic [PC_W-1:0] br_target;
   logic            cnt_clr;
   logic            cyc_inc;
   logic            ins_inc;

   // Relative target wraps modulo 2^PC_W and never touches pc_wrap.
   assign rel_target = PC_W'(SEXT_W'(ir_pc) + sext(SEXT_W'(branch_target), PC_W));
   assign br_target  = (BR_REL != 0) ? rel_target : branch_target;

   assign dbg_state = state;

   // Counters clear while start is held and throughout INIT; they only
   // advance in RUN, so IDLE and HALTED freeze them.
   assign cnt_clr = start || (state == ST_INIT);
   assign cyc_inc = (state == ST_RUN);
   assign ins_inc = (state == ST_RUN) && instr_valid && !stall;

   // Sequencer FSM and PC/IR datapath; priority start > stall > halt > branch > advance.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         instr_out   <= '0;
         ir_pc       <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         pc_wrap     <= 1'b0;
      end else if (start) begin
         state       <= ST_INIT;
         pc          <= RESET_PC;
         instr_out   <= '0;
         ir_pc       <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         pc_wrap     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_IDLE;
            end
            ST_INIT: begin
               // Reset values were loaded on entry; first fetch happens in RUN.
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (stall) begin
                  state <= ST_RUN;
               end else if (halt_req && instr_valid) begin
                  state       <= ST_HALTED;
                  halted      <= 1'b1;
                  instr_valid <= 1'b0;
               end else if (branch && instr_valid) begin
                  // Discard the sequential fetch: one bubble follows.
                  pc          <= br_target;
                  instr_valid <= 1'b0;
               end else begin
                  instr_out   <= instr_in;
                  ir_pc       <= pc;
                  instr_valid <= 1'b1;
                  pc          <= pc + 1'b1;
                  if (pc == '1) begin
                     pc_wrap <= 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               state <= ST_HALTED;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_cycle_ct (
      .CLK   (CLK),
      .RST_n (RST_n),
      .clr   (cnt_clr),
      .inc   (cyc_inc),
      .count (cycle_ct)
   );

   sat_counter #(.W(CNT_W)) u_instr_ct (
      .CLK   (CLK),
      .RST_n (RST_n),
      .clr   (cnt_clr),
      .inc   (ins_inc),
      .count (instr_ct)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: default, relative-branch and narrow
// (PC_W=4, CNT_W=3) instances, each fed by a ROM that returns its address.
module tb_fetch_sequencer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- default instance ----------------
   logic        d_start, d_stall, d_branch, d_halt;
   logic [15:0] d_tgt, d_pc, d_ir_pc;
   logic [8:0]  d_instr_in, d_instr;
   logic        d_valid, d_halted, d_wrap;
   logic [31:0] d_cyc, d_ins;
   logic [1:0]  d_state;
   assign d_instr_in = d_pc[8:0];

   fetch_sequencer u_dut (
      .CLK(clk), .RST_n(rst_n), .start(d_start), .stall(d_stall), .branch(d_branch),
      .branch_target(d_tgt), .halt_req(d_halt), .instr_in(d_instr_in), .pc(d_pc),
      .instr_out(d_instr), .ir_pc(d_ir_pc), .instr_valid(d_valid), .halted(d_halted),
      .pc_wrap(d_wrap), .cycle_ct(d_cyc), .instr_ct(d_ins), .dbg_state(d_state)
   );

   // ---------------- relative-branch instance ----------------
   logic        r_start, r_stall, r_branch, r_halt;
   logic [15:0] r_tgt, r_pc, r_ir_pc;
   logic [8:0]  r_instr_in, r_instr;
   logic        r_valid, r_halted, r_wrap;
   logic [31:0] r_cyc, r_ins;
   logic [1:0]  r_state;
   assign r_instr_in = r_pc[8:0];

   fetch_sequencer #(.BR_REL(1)) u_rel (
      .CLK(clk), .RST_n(rst_n), .start(r_start), .stall(r_stall), .branch(r_branch),
      .branch_target(r_tgt), .halt_req(r_halt), .instr_in(r_instr_in), .pc(r_pc),
      .instr_out(r_instr), .ir_pc(r_ir_pc), .instr_valid(r_valid), .halted(r_halted),
      .pc_wrap(r_wrap), .cycle_ct(r_cyc), .instr_ct(r_ins), .dbg_state(r_state)
   );

   // ---------------- narrow instance ----------------
   logic       s_start, s_stall, s_branch, s_halt;
   logic [3:0] s_tgt, s_pc, s_ir_pc;
   logic [8:0] s_instr_in, s_instr;
   logic       s_valid, s_halted, s_wrap;
   logic [2:0] s_cyc, s_ins;
   logic [1:0] s_state;
   assign s_instr_in = {5'b0, s_pc};

   fetch_sequencer #(.PC_W(4), .CNT_W(3)) u_small (
      .CLK(clk), .RST_n(rst_n), .start(s_start), .stall(s_stall), .branch(s_branch),
      .branch_target(s_tgt), .halt_req(s_halt), .instr_in(s_instr_in), .pc(s_pc),
      .instr_out(s_instr), .ir_pc(s_ir_pc), .instr_valid(s_valid), .halted(s_halted),
      .pc_wrap(s_wrap), .cycle_ct(s_cyc), .instr_ct(s_ins), .dbg_state(s_state)
   );

   // ---------------- scoreboard ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_q[$];
   logic [15:0] e;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic d_restart();
      d_start = 1'b1; tick();
      d_start = 1'b0; tick();
   endtask

   task automatic r_restart();
      r_start = 1'b1; tick();
      r_start = 1'b0; tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      {d_start, d_stall, d_branch, d_halt} = '0; d_tgt = '0;
      {r_start, r_stall, r_branch, r_halt} = '0; r_tgt = '0;
      {s_start, s_stall, s_branch, s_halt} = '0; s_tgt = '0;
      tick(); tick();
      n_tests++; if (d_state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", d_state); end
      n_tests++; if (d_pc !== 16'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0000", d_pc); end
      n_tests++; if (d_instr !== 9'h0 || d_ir_pc !== 16'h0) begin n_fail++; $display("FAIL rst_ir got %h/%h exp 0/0", d_instr, d_ir_pc); end
      n_tests++; if ({d_valid, d_halted, d_wrap} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {d_valid, d_halted, d_wrap}); end
      n_tests++; if (d_cyc !== 32'd0 || d_ins !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", d_cyc, d_ins); end
      rst_n = 1'b1;
      tick(); tick();
      n_tests++; if (d_state !== 2'd0 || d_cyc !== 32'd0 || d_valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold got st=%0d cyc=%0d v=%b exp 0/0/0", d_state, d_cyc, d_valid); end
   endtask

   task automatic test_seq_run();
      d_start = 1'b1; tick();
      n_tests++; if (d_state !== 2'd1 || d_pc !== 16'h0) begin n_fail++; $display("FAIL init got st=%0d pc=%h exp 1/0000", d_state, d_pc); end
      d_start = 1'b0; tick();
      n_tests++; if (d_state !== 2'd2 || d_pc !== 16'h0 || d_valid !== 1'b0 || d_cyc !== 32'd0) begin
         n_fail++; $display("FAIL run_entry got st=%0d pc=%h v=%b cyc=%0d exp 2/0000/0/0", d_state, d_pc, d_valid, d_cyc);
      end
      for (int k = 1; k <= 8; k++) begin
         exp_q.push_back(16'(k - 1));
         tick();
         e = exp_q.pop_front();
         n_tests++; if (d_ir_pc !== e || d_instr !== e[8:0] || d_valid !== 1'b1) begin
            n_fail++; $display("FAIL seq_ir k=%0d got ir_pc=%h ir=%h v=%b exp %h/%h/1", k, d_ir_pc, d_instr, d_valid, e, e[8:0]);
         end
         n_tests++; if (d_pc !== 16'(k) || d_cyc !== 32'(k) || d_ins !== 32'(k - 1)) begin
            n_fail++; $display("FAIL seq_pc k=%0d got pc=%h cyc=%0d ins=%0d exp %h/%0d/%0d", k, d_pc, d_cyc, d_ins, 16'(k), k, k - 1);
         end
      end
   endtask

   task automatic test_branch_abs();
      d_restart();
      repeat (6) tick();
      n_tests++; if (d_ir_pc !== 16'h5 || d_valid !== 1'b1) begin n_fail++; $display("FAIL br_pre got ir_pc=%h v=%b exp 0005/1", d_ir_pc, d_valid); end
      d_branch = 1'b1; d_tgt = 16'h0020;
      tick();
      d_branch = 1'b0;
      n_tests++; if (d_pc !== 16'h20 || d_valid !== 1'b0 || d_ins !== 32'd6 || d_cyc !== 32'd7) begin
         n_fail++; $display("FAIL br_bubble got pc=%h v=%b ins=%0d cyc=%0d exp 0020/0/6/7", d_pc, d_valid, d_ins, d_cyc);
      end
      exp_q.push_back(16'h0020);
      tick();
      e = exp_q.pop_front();
      n_tests++; if (d_ir_pc !== e || d_instr !== e[8:0] || d_valid !== 1'b1) begin
         n_fail++; $display("FAIL br_target got ir_pc=%h ir=%h v=%b exp %h/%h/1", d_ir_pc, d_instr, d_valid, e, e[8:0]);
      end
      n_tests++; if (d_pc !== 16'h21 || d_ins !== 32'd6 || d_cyc !== 32'd8) begin
         n_fail++; $display("FAIL br_after got pc=%h ins=%0d cyc=%0d exp 0021/6/8", d_pc, d_ins, d_cyc);
      end
   endtask

   task automatic test_stall();
      d_stall = 1'b1; d_branch = 1'b1; d_halt = 1'b1; d_tgt = 16'h0040;
      repeat (3) tick();
      n_tests++; if (d_pc !== 16'h21 || d_ir_pc !== 16'h20 || d_valid !== 1'b1 || d_halted !== 1'b0 || d_state !== 2'd2) begin
         n_fail++; $display("FAIL stall_hold got pc=%h ir_pc=%h v=%b h=%b st=%0d exp 0021/0020/1/0/2", d_pc, d_ir_pc, d_valid, d_halted, d_state);
      end
      n_tests++; if (d_cyc !== 32'd11 || d_ins !== 32'd6) begin n_fail++; $display("FAIL stall_cnt got cyc=%0d ins=%0d exp 11/6", d_cyc, d_ins); end
      d_stall = 1'b0; d_halt = 1'b0;
      tick();
      d_branch = 1'b0;
      n_tests++; if (d_pc !== 16'h40 || d_valid !== 1'b0 || d_ins !== 32'd7 || d_cyc !== 32'd12) begin
         n_fail++; $display("FAIL stall_branch got pc=%h v=%b ins=%0d cyc=%0d exp 0040/0/7/12", d_pc, d_valid, d_ins, d_cyc);
      end
      exp_q.push_back(16'h0040);
      tick();
      e = exp_q.pop_front();
      n_tests++; if (d_ir_pc !== e || d_instr !== e[8:0] || d_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_target got ir_pc=%h ir=%h v=%b exp %h/%h/1", d_ir_pc, d_instr, d_valid, e, e[8:0]);
      end
   endtask

   task automatic test_halt();
      d_restart();
      repeat (8) tick();
      n_tests++; if (d_ir_pc !== 16'h7 || d_valid !== 1'b1) begin n_fail++; $display("FAIL halt_pre got ir_pc=%h v=%b exp 0007/1", d_ir_pc, d_valid); end
      d_halt = 1'b1;
      tick();
      d_halt = 1'b0;
      n_tests++; if (d_halted !== 1'b1 || d_state !== 2'd3 || d_valid !== 1'b0 || d_pc !== 16'h8) begin
         n_fail++; $display("FAIL halt_enter got h=%b st=%0d v=%b pc=%h exp 1/3/0/0008", d_halted, d_state, d_valid, d_pc);
      end
      n_tests++; if (d_cyc !== 32'd9 || d_ins !== 32'd8) begin n_fail++; $display("FAIL halt_cnt got cyc=%0d ins=%0d exp 9/8", d_cyc, d_ins); end
      repeat (3) tick();
      n_tests++; if (d_pc !== 16'h8 || d_cyc !== 32'd9 || d_ins !== 32'd8 || d_halted !== 1'b1) begin
         n_fail++; $display("FAIL halt_frozen got pc=%h cyc=%0d ins=%0d h=%b exp 0008/9/8/1", d_pc, d_cyc, d_ins, d_halted);
      end
      d_start = 1'b1; tick();
      n_tests++; if (d_state !== 2'd1 || d_halted !== 1'b0 || d_pc !== 16'h0 || d_cyc !== 32'd0 || d_ins !== 32'd0) begin
         n_fail++; $display("FAIL rerun_init got st=%0d h=%b pc=%h cyc=%0d ins=%0d exp 1/0/0000/0/0", d_state, d_halted, d_pc, d_cyc, d_ins);
      end
      d_start = 1'b0; tick();
      exp_q.push_back(16'h0000);
      tick();
      e = exp_q.pop_front();
      n_tests++; if (d_ir_pc !== e || d_valid !== 1'b1 || d_cyc !== 32'd1 || d_ins !== 32'd0) begin
         n_fail++; $display("FAIL rerun_first got ir_pc=%h v=%b cyc=%0d ins=%0d exp %h/1/1/0", d_ir_pc, d_valid, d_cyc, d_ins, e);
      end
   endtask

   task automatic test_rel_branch();
      r_restart();
      tick();
      n_tests++; if (r_ir_pc !== 16'h0 || r_valid !== 1'b1) begin n_fail++; $display("FAIL rel_pre0 got ir_pc=%h v=%b exp 0000/1", r_ir_pc, r_valid); end
      r_branch = 1'b1; r_tgt = 16'hFFFF;
      tick();
      r_branch = 1'b0;
      n_tests++; if (r_pc !== 16'hFFFF || r_valid !== 1'b0 || r_wrap !== 1'b0) begin
         n_fail++; $display("FAIL rel_neg1 got pc=%h v=%b wrap=%b exp ffff/0/0", r_pc, r_valid, r_wrap);
      end
      exp_q.push_back(16'hFFFF);
      tick();
      e = exp_q.pop_front();
      n_tests++; if (r_ir_pc !== e || r_instr !== e[8:0] || r_pc !== 16'h0 || r_wrap !== 1'b1) begin
         n_fail++; $display("FAIL rel_wrap got ir_pc=%h ir=%h pc=%h wrap=%b exp %h/%h/0000/1", r_ir_pc, r_instr, r_pc, r_wrap, e, e[8:0]);
      end
      r_restart();
      n_tests++; if (r_wrap !== 1'b0) begin n_fail++; $display("FAIL rel_wrap_clr got %b exp 0", r_wrap); end
      repeat (17) tick();
      n_tests++; if (r_ir_pc !== 16'h10) begin n_fail++; $display("FAIL rel_pre10 got ir_pc=%h exp 0010", r_ir_pc); end
      r_branch = 1'b1; r_tgt = 16'hFFFC;
      tick();
      r_branch = 1'b0;
      n_tests++; if (r_pc !== 16'h000C || r_valid !== 1'b0) begin n_fail++; $display("FAIL rel_minus4 got pc=%h v=%b exp 000c/0", r_pc, r_valid); end
      exp_q.push_back(16'h000C);
      tick();
      e = exp_q.pop_front();
      n_tests++; if (r_ir_pc !== e || r_instr !== e[8:0] || r_valid !== 1'b1) begin
         n_fail++; $display("FAIL rel_target got ir_pc=%h ir=%h v=%b exp %h/%h/1", r_ir_pc, r_instr, r_valid, e, e[8:0]);
      end
   endtask

   task automatic test_wrap_sat();
      s_start = 1'b1; tick();
      s_start = 1'b0; tick();
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k == 7) begin
            n_tests++; if (s_cyc !== 3'd7 || s_ins !== 3'd6) begin n_fail++; $display("FAIL sat_k7 got cyc=%0d ins=%0d exp 7/6", s_cyc, s_ins); end
         end
         if (k == 15) begin
            n_tests++; if (s_pc !== 4'hF || s_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_k15 got pc=%h wrap=%b exp f/0", s_pc, s_wrap); end
         end
         if (k == 16) begin
            n_tests++; if (s_pc !== 4'h0 || s_wrap !== 1'b1 || s_ir_pc !== 4'hF) begin
               n_fail++; $display("FAIL wrap_k16 got pc=%h wrap=%b ir_pc=%h exp 0/1/f", s_pc, s_wrap, s_ir_pc);
            end
            n_tests++; if (s_cyc !== 3'd7 || s_ins !== 3'd7) begin n_fail++; $display("FAIL sat_k16 got cyc=%0d ins=%0d exp 7/7", s_cyc, s_ins); end
         end
         if (k == 17) begin
            n_tests++; if (s_wrap !== 1'b1 || s_pc !== 4'h1 || s_ir_pc !== 4'h0) begin
               n_fail++; $display("FAIL wrap_sticky got wrap=%b pc=%h ir_pc=%h exp 1/1/0", s_wrap, s_pc, s_ir_pc);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_tests++; if (s_pc !== 4'h0 || s_wrap !== 1'b0 || s_valid !== 1'b0 || s_state !== 2'd0) begin
         n_fail++; $display("FAIL arst_state got pc=%h wrap=%b v=%b st=%0d exp 0/0/0/0", s_pc, s_wrap, s_valid, s_state);
      end
      n_tests++; if (s_cyc !== 3'd0 || s_ins !== 3'd0 || s_ir_pc !== 4'h0 || s_instr !== 9'h0) begin
         n_fail++; $display("FAIL arst_regs got cyc=%0d ins=%0d ir_pc=%h ir=%h exp 0/0/0/0", s_cyc, s_ins, s_ir_pc, s_instr);
      end
      n_tests++; if (r_state !== 2'd0 || d_state !== 2'd0) begin n_fail++; $display("FAIL arst_others got r=%0d d=%0d exp 0/0", r_state, d_state); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_seq_run();
      test_branch_abs();
      test_stall();
      test_halt();
      test_rel_branch();
      test_wrap_sat();
      test_async_reset();
      if (exp_q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
